// File: rtl/seg_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module  : seg_pkg                                                  |
// | Brief   : shared types and defaults for the 7-segment scan block   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  typedef logic [3:0] nibble_t;

  localparam int SEG_NDIG = 4;
  localparam int SEG_DIV  = 1000;
  localparam int SEG_GAP  = 16;

  function automatic int seg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_prescaler.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module  : seg_prescaler                                            |
// | Brief   : loadable down-counter, tc high while the count is zero   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg_prescaler #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] r_cnt;

  // Holds at zero until reloaded, so tc marks the last cycle of a phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module  : seg_scan_ctrl                                            |
// | Brief   : double-buffered multiplexed 7-segment digit scanner      |
// |           Option macro SEG_LZ_BLANK_EN: leading-zero suppression   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG = SEG_NDIG,
  parameter int DIV  = SEG_DIV,
  parameter int GAP  = SEG_GAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  output logic [3:0]        nib_out,
  output logic [NDIG-1:0]   dig_sel,
  output logic              blank,
  output logic              frame_done
);

  localparam int              c_CW     = $clog2(seg_max(DIV, GAP) + 1);
  localparam int              c_IW     = $clog2(NDIG);
  localparam logic [c_CW-1:0] c_DIV_LD = c_CW'(DIV - 1);
  localparam logic [c_CW-1:0] c_GAP_LD = c_CW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [c_IW-1:0] c_LAST   = c_IW'(NDIG - 1);
  localparam logic [NDIG-1:0] c_ONE    = NDIG'(1);

  scan_state_t       r_state, w_state_nxt;
  logic [c_IW-1:0]   r_idx, w_idx_nxt;
  logic [4*NDIG-1:0] r_active, w_active_nxt;
  logic [4*NDIG-1:0] r_pend;
  logic              r_pend_vld, w_pend_vld_nxt;
  logic              w_load, w_tc, w_boundary, w_accept;
  logic [c_CW-1:0]   w_load_val;
  logic [NDIG-1:0]   w_lz, w_dig_sel;
  nibble_t           w_nib;
  logic              w_blank;

  logic [NDIG-1:0]   r_dig_sel;
  nibble_t           r_nib;
  logic              r_blank, r_frame_done, r_load_ready;

  seg_prescaler #(
    .W       (c_CW),
    .RST_VAL (c_GAP_LD)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BLANK;
      r_idx      <= '0;
      r_active   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_active   <= w_active_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      if (w_accept) begin
        r_pend <= load_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_load_val  = c_DIV_LD;
    w_boundary  = 1'b0;
    case (r_state)
      BLANK: begin
        if (w_tc) begin
          w_state_nxt = SHOW;
          w_load      = 1'b1;
        end
      end
      SHOW: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_boundary = (r_idx == c_LAST);
          w_idx_nxt  = (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
          // Without a gap the next digit's SHOW follows directly.
          if (GAP > 0) begin
            w_state_nxt = BLANK;
            w_load_val  = c_GAP_LD;
          end
        end
      end
      default: w_state_nxt = BLANK;
    endcase
  end

  // A frame accepted at the boundary itself lands in pend and waits a frame.
  assign w_accept       = load_valid & ~r_pend_vld;
  assign w_active_nxt   = (w_boundary & r_pend_vld) ? r_pend : r_active;
  assign w_pend_vld_nxt = w_accept | (r_pend_vld & ~w_boundary);

`ifdef SEG_LZ_BLANK_EN
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_lz
    if (gi == 0) begin : g_d0
      assign w_lz[gi] = 1'b0;
    end else begin : g_dn
      assign w_lz[gi] = (w_active_nxt[4*NDIG-1:4*gi] == '0);
    end
  end
`else
  assign w_lz = '0;
`endif

  // Outputs are derived from next-state values so the registers track the FSM.
  always_comb begin
    w_dig_sel = '0;
    if (w_state_nxt == SHOW) begin
      w_dig_sel = c_ONE << w_idx_nxt;
    end
    w_dig_sel = w_dig_sel & ~w_lz;
    w_nib     = nibble_t'(w_active_nxt >> {w_idx_nxt, 2'b00});
    w_blank   = (w_dig_sel == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_sel    <= '0;
      r_nib        <= '0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_dig_sel    <= w_dig_sel;
      r_nib        <= w_nib;
      r_blank      <= w_blank;
      r_frame_done <= w_boundary;
      r_load_ready <= ~w_pend_vld_nxt;
    end
  end

  assign dig_sel    = r_dig_sel;
  assign nib_out    = r_nib;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;
  assign load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module  : tb_seg_scan_ctrl                                         |
// | Brief   : scoreboard bench for seg_scan_ctrl (NDIG=4 DIV=4 GAP=2)  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 4;
  localparam int GAP  = 2;
  localparam int SLOT = GAP + DIV;
  localparam int FR   = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_ready, blank, frame_done;
  logic [3:0]  nib_out, dig_sel;

  logic        lv0 = 1'b0;
  logic [15:0] ld0 = '0;
  logic        rdy0, blank0, fd0;
  logic [3:0]  nib0, dig0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [3:0] nib;
    logic       blank;
    logic       fd;
    logic       rdy;
  } obs_t;

  obs_t        q_exp[$];
  int          m_k;
  logic [15:0] m_act, m_pend;
  logic        m_pv;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .nib_out(nib_out), .dig_sel(dig_sel), .blank(blank),
    .frame_done(frame_done)
  );

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_ready(rdy0),
    .load_data(ld0), .nib_out(nib0), .dig_sel(dig0), .blank(blank0),
    .frame_done(fd0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t dut_obs();
    return {dig_sel, nib_out, blank, frame_done, load_ready};
  endfunction

  task automatic model_reset();
    m_k = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
    q_exp.delete();
  endtask

  // Expected outputs for cycle m_k follow from elapsed time since reset release.
  task automatic model_step(input logic v, input logic [15:0] d);
    obs_t e;
    int   t, s, o;
    logic acc;
    t = m_k % FR; s = t / SLOT; o = t % SLOT;
    e.dig = (o >= GAP) ? 4'(1 << s) : 4'h0;
`ifdef SEG_LZ_BLANK_EN
    if (s > 0 && (m_act >> (4 * s)) == 16'h0) e.dig = 4'h0;
`endif
    e.nib   = m_act[4*s +: 4];
    e.blank = (e.dig == 4'h0);
    e.fd    = (m_k > 0) && (t == 0);
    e.rdy   = !m_pv;
    q_exp.push_back(e);
    acc = v && !m_pv;
    if (t == FR - 1 && m_pv) begin
      m_act = m_pend; m_pv = 1'b0;
    end
    if (acc) begin
      m_pend = d; m_pv = 1'b1;
    end
    m_k++;
  endtask

  task automatic tick(input logic v, input logic [15:0] d);
    load_valid = v; load_data = d;
    model_step(v, d);
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    e = '{dig: 4'h0, nib: 4'h0, blank: 1'b1, fd: 1'b0, rdy: 1'b1};
    o = dut_obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_values got {dig,nib,blank,fd,rdy}=%b want %b", o, e);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      tick(1'b0, 16'h0);
      e = q_exp.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL idle_scan k=%0d got %b want %b", m_k - 1, o, e);
      end
      next_cycle();
    end
  endtask

  // Holds load_valid until the reference handshake takes the frame.
  task automatic send_frame(input logic [15:0] d, input string name);
    obs_t e, o;
    logic sent, acc;
    int   n;
    sent = 1'b0; n = 0;
    while (!sent && n < 200) begin
      acc = !m_pv;
      tick(1'b1, d);
      sent = acc;
      e = q_exp.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s k=%0d got %b want %b", name, m_k - 1, o, e);
      end
      next_cycle(); n++;
    end
    load_valid = 1'b0;
    if (!sent) begin
      checks++; errors++;
      $display("FAIL %s_timeout got not-accepted want accepted", name);
    end
  endtask

  task automatic run_idle(input int cycles, input string name);
    obs_t e, o;
    for (int i = 0; i < cycles; i++) begin
      tick(1'b0, 16'h0);
      e = q_exp.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s k=%0d got %b want %b", name, m_k - 1, o, e);
      end
      next_cycle();
    end
  endtask

  task automatic test_load();
    run_idle(3, "pre_load");
    send_frame(16'h4321, "load_4321");
    run_idle(2 * FR, "show_4321");
  endtask

  task automatic test_back_to_back();
    send_frame(16'hA5A5, "load_a5a5");
    send_frame(16'hBEEF, "load_beef_held");
    run_idle(3 * FR, "show_beef");
  endtask

  task automatic test_boundary_load();
    obs_t e, o;
    int   n;
    n = 0;
    while (!((m_k % FR) == FR - 1 && !m_pv) && n < 200) begin
      tick(1'b0, 16'h0);
      e = q_exp.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pre_boundary k=%0d got %b want %b", m_k - 1, o, e);
      end
      next_cycle(); n++;
    end
    tick(1'b1, 16'h9876);
    e = q_exp.pop_front(); o = dut_obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL boundary_load k=%0d got %b want %b", m_k - 1, o, e);
    end
    next_cycle();
    load_valid = 1'b0;
    run_idle(2 * FR + 6, "show_9876");
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    int   n;
    n = 0;
    while ((m_k % FR) != 2 * SLOT + GAP + 1 && n < 200) begin
      tick(1'b0, 16'h0);
      e = q_exp.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pre_reset k=%0d got %b want %b", m_k - 1, o, e);
      end
      next_cycle(); n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dig_sel !== 4'h0) begin
      errors++;
      $display("FAIL async_reset_dig got %b want 0000", dig_sel);
    end
    checks++;
    if (blank !== 1'b1 || load_ready !== 1'b1 || nib_out !== 4'h0) begin
      errors++;
      $display("FAIL async_reset_flags got blank=%b rdy=%b nib=%h want 1 1 0",
               blank, load_ready, nib_out);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    run_idle(FR + 6, "after_reset");
  endtask

  task automatic test_lz();
    obs_t e, o;
    int   nblank, nfd, want_blank;
    lv0 = 1'b1; ld0 = 16'h0070;
    tick(1'b1, 16'h0070);
    e = q_exp.pop_front(); o = dut_obs(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL lz_load k=%0d got %b want %b", m_k - 1, o, e);
    end
    next_cycle();
    lv0 = 1'b0; load_valid = 1'b0;
    nblank = 0; nfd = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 16'h0);
      e = q_exp.pop_front(); o = dut_obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lz_scan k=%0d got %b want %b", m_k - 1, o, e);
      end
      if (i >= 44) begin
        if (blank0) nblank++;
        if (fd0) nfd++;
      end
      next_cycle();
    end
`ifdef SEG_LZ_BLANK_EN
    want_blank = 8;
`else
    want_blank = 0;
`endif
    checks++;
    if (nblank != want_blank) begin
      errors++;
      $display("FAIL gap0_blank_count got %0d want %0d", nblank, want_blank);
    end
    checks++;
    if (nfd != 1) begin
      errors++;
      $display("FAIL gap0_frame_done_count got %0d want 1", nfd);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_boundary_load();
    test_reset_mid();
    test_lz();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
